// File: rtl/uart_fb_select.sv
// uart_fb_select
//   Decodes single-byte UART commands into a framebuffer base address for
//   the VGA scan-out. Images sit at a fixed stride. Commands select an image
//   directly, by next/prev, or load a raw 24-bit address ('B' + 3 bytes).
//   Every command that produces a reply queues one byte on the TX handshake.
//
// Ports
//   CLK, rst            clock, synchronous active-high reset
//   rx_data/rx_valid    received byte and its one-cycle strobe
//   base_addr           framebuffer base address to vga_basic
//   img_idx             current image index
//   custom_mode         1 when base_addr came from a raw 'B' load
//   tx_data/tx_valid    response byte and pending flag
//   tx_ready            uart_core accepts tx_data when tx_valid && tx_ready
//   busy                1 while a 'B' sequence is in progress
//   overrun             one-cycle pulse when a pending response is replaced
module uart_fb_select #(
  parameter int ADDR_W      = 17,
  parameter int NUM_IMG     = 4,
  parameter int IMG_STRIDE  = 49152,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int IDX_W      = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] base_addr,
  output logic [IDX_W-1:0]  img_idx,
  output logic              custom_mode,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_IMG - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADR2 = 2'd1,
    ST_ADR1 = 2'd2,
    ST_ADR0 = 2'd3
  } state_t;

  state_t             state_r, state_nxt;
  logic [7:0]         hi_r, hi_nxt;
  logic [7:0]         mid_r, mid_nxt;
  logic [TMO_W-1:0]   tmo_r, tmo_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [ADDR_W-1:0]  base_nxt;
  logic               custom_nxt;
  logic               resp_s;
  logic [7:0]         resp_byte_s;
  logic               tmo_hit_s;
  logic               is_b_s;
  logic [7:0]         digit_s;

  // Indexed-mode address; the product is wide enough that truncation gives the modulo.
  function automatic logic [ADDR_W-1:0] idx_base(input logic [IDX_W-1:0] idx);
    return ADDR_W'(64'(idx) * 64'(IMG_STRIDE));
  endfunction

  assign is_b_s    = (rx_data == 8'h42) || (rx_data == 8'h62);
  assign digit_s   = rx_data - 8'h30;
  // Timeout fires on the idle cycle that would push the counter past its last value.
  assign tmo_hit_s = (state_r != ST_IDLE) && !rx_valid && (tmo_r == TMO_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic: each address state consumes one byte or times out.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && is_b_s) state_nxt = ST_ADR2;
        else                    state_nxt = ST_IDLE;
      end
      ST_ADR2: begin
        if (rx_valid)       state_nxt = ST_ADR1;
        else if (tmo_hit_s) state_nxt = ST_IDLE;
        else                state_nxt = ST_ADR2;
      end
      ST_ADR1: begin
        if (rx_valid)       state_nxt = ST_ADR0;
        else if (tmo_hit_s) state_nxt = ST_IDLE;
        else                state_nxt = ST_ADR1;
      end
      ST_ADR0: begin
        if (rx_valid || tmo_hit_s) state_nxt = ST_IDLE;
        else                       state_nxt = ST_ADR0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath logic: command decode, address assembly, timeout, response.
  always_comb begin
    idx_nxt     = img_idx;
    base_nxt    = base_addr;
    custom_nxt  = custom_mode;
    hi_nxt      = hi_r;
    mid_nxt     = mid_r;
    tmo_nxt     = tmo_r;
    resp_s      = 1'b0;
    resp_byte_s = 8'h00;
    case (state_r)
      ST_IDLE: begin
        tmo_nxt = {TMO_W{1'b0}};
        if (rx_valid) begin
          case (rx_data)
            8'h41, 8'h61: begin
              idx_nxt = {IDX_W{1'b0}};
              base_nxt = idx_base({IDX_W{1'b0}});
              custom_nxt = 1'b0;
              resp_s = 1'b1; resp_byte_s = ACK;
            end
            8'h46, 8'h66: begin
              resp_s = 1'b1;
              if (NUM_IMG >= 2) begin
                idx_nxt = IDX_W'(1);
                base_nxt = idx_base(IDX_W'(1));
                custom_nxt = 1'b0;
                resp_byte_s = ACK;
              end else begin
                resp_byte_s = NAK;
              end
            end
            8'h4E, 8'h6E: begin
              idx_nxt = (img_idx == IDX_MAX) ? {IDX_W{1'b0}} : img_idx + IDX_W'(1);
              base_nxt = idx_base(idx_nxt);
              custom_nxt = 1'b0;
              resp_s = 1'b1; resp_byte_s = ACK;
            end
            8'h50, 8'h70: begin
              idx_nxt = (img_idx == {IDX_W{1'b0}}) ? IDX_MAX : img_idx - IDX_W'(1);
              base_nxt = idx_base(idx_nxt);
              custom_nxt = 1'b0;
              resp_s = 1'b1; resp_byte_s = ACK;
            end
            8'h3F: begin
              resp_s = 1'b1;
              resp_byte_s = 8'h30 + 8'(img_idx);
            end
            // 'B' only moves the FSM; CR, LF and space are silently dropped.
            8'h42, 8'h62, 8'h0D, 8'h0A, 8'h20: begin
              resp_s = 1'b0;
            end
            default: begin
              resp_s = 1'b1;
              if ((rx_data >= 8'h30) && (rx_data <= 8'h39) &&
                  ({24'd0, digit_s} < 32'(NUM_IMG))) begin
                idx_nxt = IDX_W'(digit_s);
                base_nxt = idx_base(IDX_W'(digit_s));
                custom_nxt = 1'b0;
                resp_byte_s = ACK;
              end else begin
                resp_byte_s = NAK;
              end
            end
          endcase
        end else begin
          resp_s = 1'b0;
        end
      end
      ST_ADR2, ST_ADR1, ST_ADR0: begin
        if (rx_valid) begin
          tmo_nxt = {TMO_W{1'b0}};
          if (state_r == ST_ADR2) begin
            hi_nxt = rx_data;
          end else if (state_r == ST_ADR1) begin
            mid_nxt = rx_data;
          end else begin
            base_nxt = ADDR_W'({hi_r, mid_r, rx_data});
            custom_nxt = 1'b1;
            resp_s = 1'b1; resp_byte_s = ACK;
          end
        end else if (tmo_hit_s) begin
          tmo_nxt = {TMO_W{1'b0}};
          resp_s = 1'b1; resp_byte_s = NAK;
        end else begin
          tmo_nxt = tmo_r + TMO_W'(1);
        end
      end
      default: begin
        tmo_nxt = {TMO_W{1'b0}};
      end
    endcase
  end

  // Registered outputs and datapath; a new response wins over a same-edge tx_ready clear.
  always_ff @(posedge CLK) begin
    if (rst) begin
      base_addr   <= {ADDR_W{1'b0}};
      img_idx     <= {IDX_W{1'b0}};
      custom_mode <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      hi_r        <= 8'h00;
      mid_r       <= 8'h00;
      tmo_r       <= {TMO_W{1'b0}};
    end else begin
      base_addr   <= base_nxt;
      img_idx     <= idx_nxt;
      custom_mode <= custom_nxt;
      busy        <= (state_nxt != ST_IDLE);
      hi_r        <= hi_nxt;
      mid_r       <= mid_nxt;
      tmo_r       <= tmo_nxt;
      if (resp_s) begin
        tx_valid <= 1'b1;
        tx_data  <= resp_byte_s;
        overrun  <= tx_valid && !tx_ready;
      end else begin
        overrun <= 1'b0;
        if (tx_ready) tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_fb_select.sv
// Randomized self-checking bench for uart_fb_select with a byte-level
// behavioural reference model (image index arithmetic, pending-byte count,
// idle-cycle count, and a one-deep TX slot).
module tb_uart_fb_select;
  localparam int ADDR_W      = 17;
  localparam int NUM_IMG     = 4;
  localparam int IMG_STRIDE  = 49152;
  localparam int TIMEOUT_CYC = 16;
  localparam int IDX_W       = 2;

  logic              CLK = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [ADDR_W-1:0] base_addr;
  logic [IDX_W-1:0]  img_idx;
  logic              custom_mode;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic              overrun;

  uart_fb_select #(
    .ADDR_W(ADDR_W), .NUM_IMG(NUM_IMG), .IMG_STRIDE(IMG_STRIDE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .base_addr(base_addr), .img_idx(img_idx), .custom_mode(custom_mode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_idx, m_base, m_custom, m_pending, m_idle, m_addr, m_txv, m_txd, m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_base = 0; m_custom = 0; m_pending = 0; m_idle = 0;
    m_addr = 0; m_txv = 0; m_txd = 0; m_ovr = 0;
  endtask

  task automatic model_set_idx(input int i);
    m_idx = i;
    m_base = (i * IMG_STRIDE) % (1 << ADDR_W);
    m_custom = 0;
  endtask

  task automatic model_step(input bit v, input int b, input bit rdy);
    int resp;
    int c;
    resp = -1;
    if (m_pending > 0) begin
      if (v) begin
        m_idle = 0;
        m_addr = (m_addr << 8) | b;
        m_pending--;
        if (m_pending == 0) begin
          m_base = m_addr % (1 << ADDR_W);
          m_custom = 1;
          resp = "K";
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          m_pending = 0; m_idle = 0; resp = "!";
        end
      end
    end else if (v) begin
      c = b;
      if (c >= "a" && c <= "z") c = c - 32;
      if (c == "A") begin model_set_idx(0); resp = "K"; end
      else if (c == "F") begin
        if (NUM_IMG >= 2) begin model_set_idx(1); resp = "K"; end
        else resp = "!";
      end
      else if (c >= "0" && c <= "9") begin
        if (c - "0" < NUM_IMG) begin model_set_idx(c - "0"); resp = "K"; end
        else resp = "!";
      end
      else if (c == "N") begin model_set_idx((m_idx + 1) % NUM_IMG); resp = "K"; end
      else if (c == "P") begin model_set_idx((m_idx + NUM_IMG - 1) % NUM_IMG); resp = "K"; end
      else if (c == "?") resp = "0" + m_idx;
      else if (c == "B") begin m_pending = 3; m_addr = 0; m_idle = 0; end
      else if (c == 13 || c == 10 || c == 32) resp = -1;
      else resp = "!";
    end
    if (resp >= 0) begin
      m_ovr = (m_txv != 0 && !rdy) ? 1 : 0;
      m_txv = 1;
      m_txd = resp;
    end else begin
      m_ovr = 0;
      if (rdy) m_txv = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("base_addr", 32'(base_addr), m_base);
    check_eq("img_idx", 32'(img_idx), m_idx);
    check_eq("custom_mode", 32'(custom_mode), m_custom);
    check_eq("busy", 32'(busy), (m_pending > 0) ? 1 : 0);
    check_eq("tx_valid", 32'(tx_valid), m_txv);
    check_eq("tx_data", 32'(tx_data), m_txd);
    check_eq("overrun", 32'(overrun), m_ovr);
  endtask

  task automatic cyc(input bit v, input logic [7:0] b, input bit rdy);
    rx_valid = v; rx_data = b; tx_ready = rdy;
    @(posedge CLK);
    model_step(v, int'(b), rdy);
    #1;
    rx_valid = 1'b0;
    compare_all();
  endtask

  // Reset with a command byte presented on the same edge; it must be ignored.
  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_data = "F"; tx_ready = 1'b0;
    @(posedge CLK);
    model_reset();
    #1;
    rst = 1'b0; rx_valid = 1'b0;
    compare_all();
  endtask

  logic [7:0] pool [0:24];

  initial begin
    pool = '{"A", "a", "F", "f", "0", "1", "2", "3", "4", "9", "N", "n", "P", "p",
             "?", "B", "b", 8'h0D, 8'h0A, " ", "x", "Z", "K", 8'hFF, 8'h00};
    model_reset();

    do_reset();
    check_eq("reset_base", 32'(base_addr), 32'd0);
    check_eq("reset_txv", 32'(tx_valid), 32'd0);

    cyc(1, "F", 0);
    check_eq("F_base", 32'(base_addr), 32'd49152);
    check_eq("F_tx", 32'(tx_data), 32'h4B);
    cyc(1, "a", 1);
    check_eq("a_base", 32'(base_addr), 32'd0);
    cyc(1, "3", 1);
    check_eq("d3_base", 32'(base_addr), 32'd16384);
    cyc(1, "7", 1);
    check_eq("d7_nak", 32'(tx_data), 32'h21);
    check_eq("d7_base", 32'(base_addr), 32'd16384);
    cyc(1, "N", 1);
    check_eq("N_wrap", 32'(img_idx), 32'd0);
    cyc(1, "P", 1);
    check_eq("P_wrap", 32'(img_idx), 32'd3);
    cyc(1, "?", 1);
    check_eq("query", 32'(tx_data), 32'h33);

    cyc(1, "B", 1); cyc(1, 8'h01, 1); cyc(1, 8'h23, 1); cyc(1, 8'h45, 1);
    check_eq("B_base", 32'(base_addr), 32'h12345);
    check_eq("B_custom", 32'(custom_mode), 32'd1);
    cyc(1, "N", 1);
    check_eq("N_custom", 32'(custom_mode), 32'd0);

    cyc(1, "B", 1); cyc(1, 8'h00, 1);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) cyc(0, 8'h00, 1);
    check_eq("tmo_not_yet", 32'(busy), 32'd1);
    cyc(0, 8'h00, 0);
    check_eq("tmo_nak", 32'(tx_data), 32'h21);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    cyc(0, 8'h00, 1);

    cyc(1, "F", 0);
    cyc(1, "a", 0);
    check_eq("ovr_pulse", 32'(overrun), 32'd1);
    check_eq("ovr_data", 32'(tx_data), 32'h4B);
    cyc(0, 8'h00, 0);
    check_eq("ovr_once", 32'(overrun), 32'd0);

    cyc(1, "B", 1); cyc(1, 8'h01, 0);
    do_reset();
    check_eq("rst_busy", 32'(busy), 32'd0);
    cyc(1, "F", 1);
    check_eq("post_rst_F", 32'(img_idx), 32'd1);

    // Random traffic with busy rx, then sparse rx so timeouts occur.
    for (int i = 0; i < 3000; i++) begin
      automatic bit v;
      automatic logic [7:0] b;
      if (i < 1500) v = ($urandom_range(0, 2) == 0);
      else          v = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 4) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 24)];
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(v, b, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
